// File: rtl/ring_pkg.sv
// Shared types and default cadence constants for the ring cadence generator.
//   ring_state_e     : controller state encoding
//   Default*         : default on/off burst lengths and ring limit
//   max_u            : helper for deriving counter widths
package ring_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRingOn,
    StRingOff,
    StHold
  } ring_state_e;

  localparam int unsigned DefaultOnCycles  = 4;
  localparam int unsigned DefaultOffCycles = 4;
  localparam int unsigned DefaultMaxRings  = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ring_phase_counter.sv
// Phase counter for the ring cadence: clears or increments each cycle and flags when the
// current count equals a caller-supplied terminal value.
//   clk         : clock
//   reset_n     : asynchronous active-low reset
//   clear       : load zero on the next edge (takes priority over inc)
//   inc         : increment on the next edge
//   terminal    : value at which at_terminal asserts
//   at_terminal : count == terminal (combinational compare on the registered count)
module ring_phase_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign at_terminal = (count_q == terminal);

endmodule

// File: rtl/ring_cadence_gen.sv
// Call-side alert initiator. Emits an on/off ring cadence while a call is incoming and stops
// it on answer, dismiss, caller hang-up or after MAX_RINGS bursts, reporting the outcome as
// one-cycle status pulses on the first cycle of HOLD.
//   clk        : clock
//   reset_n    : asynchronous active-low reset
//   call_req   : level, high while a call is incoming
//   answer     : user answer request
//   dismiss    : user reject request
//   ring       : ring request to the ringer/motor selector (high in the on phase)
//   busy       : high whenever the controller is not idle
//   answered   : one-cycle pulse, call answered
//   rejected   : one-cycle pulse, call dismissed
//   missed     : one-cycle pulse, MAX_RINGS bursts elapsed unanswered
//   ring_count : completed bursts for the current call
module ring_cadence_gen
  import ring_pkg::*;
#(
  parameter  int unsigned ON_CYCLES  = DefaultOnCycles,
  parameter  int unsigned OFF_CYCLES = DefaultOffCycles,
  parameter  int unsigned MAX_RINGS  = DefaultMaxRings,
  localparam int unsigned CNT_W      = $clog2(max_u(ON_CYCLES, OFF_CYCLES) + 1),
  localparam int unsigned RC_W       = $clog2(MAX_RINGS + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            call_req,
  input  logic            answer,
  input  logic            dismiss,
  output logic            ring,
  output logic            busy,
  output logic            answered,
  output logic            rejected,
  output logic            missed,
  output logic [RC_W-1:0] ring_count
);

  ring_state_e      state;
  logic             cadence_active;
  logic             call_event;
  logic             phase_done;
  logic             phase_inc;
  logic             phase_clear;
  logic [CNT_W-1:0] phase_term;
  logic [RC_W-1:0]  ring_count_inc;

  assign cadence_active = (state == StRingOn) || (state == StRingOff);
  // Any of these leaves the cadence, so the phase must restart from zero next time.
  assign call_event     = !call_req || answer || dismiss;
  assign ring_count_inc = ring_count + RC_W'(1);

  always_comb begin
    phase_term  = (state == StRingOn) ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1);
    phase_inc   = cadence_active && !call_event && !phase_done;
    phase_clear = !phase_inc;
  end

  ring_phase_counter #(
    .CNT_W(CNT_W)
  ) u_phase (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (phase_clear),
    .inc        (phase_inc),
    .terminal   (phase_term),
    .at_terminal(phase_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      ring_count <= '0;
      answered   <= 1'b0;
      rejected   <= 1'b0;
      missed     <= 1'b0;
    end else begin
      answered <= 1'b0;
      rejected <= 1'b0;
      missed   <= 1'b0;
      unique case (state)
        StIdle: begin
          if (call_req) begin
            state      <= StRingOn;
            ring_count <= '0;
          end
        end
        StRingOn, StRingOff: begin
          // User/caller events outrank the cadence timer, including on the final burst.
          if (!call_req) begin
            state      <= StIdle;
            ring_count <= '0;
          end else if (answer) begin
            state    <= StHold;
            answered <= 1'b1;
          end else if (dismiss) begin
            state    <= StHold;
            rejected <= 1'b1;
          end else if (phase_done) begin
            if (state == StRingOn) begin
              ring_count <= ring_count_inc;
              if (ring_count_inc == RC_W'(MAX_RINGS)) begin
                state  <= StHold;
                missed <= 1'b1;
              end else begin
                state <= StRingOff;
              end
            end else begin
              state <= StRingOn;
            end
          end
        end
        StHold: begin
          if (!call_req) begin
            state      <= StIdle;
            ring_count <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Moore outputs straight from state so reset drops them without a clock edge.
  assign ring = (state == StRingOn);
  assign busy = (state != StIdle);

endmodule

// File: tb/tb_ring_cadence_gen.sv
module tb_ring_cadence_gen;

  localparam int unsigned ON   = 4;
  localparam int unsigned OFF  = 4;
  localparam int unsigned MAXR = 3;
  localparam int unsigned PER  = ON + OFF;
  localparam int unsigned RC_W = $clog2(MAXR + 1);

  logic            clk = 1'b0;
  logic            reset_n;
  logic            call_req;
  logic            answer;
  logic            dismiss;
  logic            ring;
  logic            busy;
  logic            answered;
  logic            rejected;
  logic            missed;
  logic [RC_W-1:0] ring_count;

  always #5 clk = ~clk;

  ring_cadence_gen #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .MAX_RINGS (MAXR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .call_req  (call_req),
    .answer    (answer),
    .dismiss   (dismiss),
    .ring      (ring),
    .busy      (busy),
    .answered  (answered),
    .rejected  (rejected),
    .missed    (missed),
    .ring_count(ring_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 hold. Cadence position is plain elapsed time
  // since the call started ringing; bursts completed follow from division by the period.
  int m_mode;
  int m_elapsed;
  int m_cnt;
  int m_pulse;  // 0 none, 1 answered, 2 rejected, 3 missed

  function automatic logic [7:0] pack(input logic r, input logic b, input logic a,
                                      input logic j, input logic m, input int c);
    return {r, b, a, j, m, 3'(c)};
  endfunction

  function logic [7:0] dut_vec();
    return {ring, busy, answered, rejected, missed, 3'(ring_count)};
  endfunction

  function logic [7:0] model_vec();
    logic r;
    r = (m_mode == 1) && ((m_elapsed % PER) < ON);
    return pack(r, m_mode != 0, m_pulse == 1, m_pulse == 2, m_pulse == 3, m_cnt);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h (ring,busy,ans,rej,miss,cnt[2:0])",
               name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_elapsed = 0;
    m_cnt     = 0;
    m_pulse   = 0;
  endtask

  task automatic model_step(input logic c, input logic a, input logic d);
    int done;
    m_pulse = 0;
    case (m_mode)
      0: if (c) begin
        m_mode    = 1;
        m_elapsed = 0;
        m_cnt     = 0;
      end
      1: begin
        if (!c) begin
          m_mode = 0;
          m_cnt  = 0;
        end else if (a) begin
          m_mode  = 2;
          m_pulse = 1;
        end else if (d) begin
          m_mode  = 2;
          m_pulse = 2;
        end else begin
          m_elapsed++;
          done  = (m_elapsed < ON) ? 0 : (m_elapsed - ON) / PER + 1;
          m_cnt = done;
          if (done == MAXR) begin
            m_mode  = 2;
            m_pulse = 3;
          end
        end
      end
      default: if (!c) begin
        m_mode = 0;
        m_cnt  = 0;
      end
    endcase
  endtask

  // Drive inputs for one cycle, advance across the edge, compare against the model.
  task automatic tick(input logic c, input logic a, input logic d, input string tag);
    call_req = c;
    answer   = a;
    dismiss  = d;
    @(posedge clk);
    model_step(c, a, d);
    @(negedge clk);
    check({tag, " model"}, dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    call_req = 1'b0;
    answer   = 1'b0;
    dismiss  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset state", dut_vec(), 8'h00);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic       cr;
    logic       an;
    logic       di;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Timeout path: entry k holds inputs of cycle k and outputs expected in cycle k+1.
    for (int k = 0; k < 23; k++) begin
      int   n;
      logic r;
      int   c;
      n = k + 1;
      r = (n >= 1 && n <= 4) || (n >= 9 && n <= 12) || (n >= 17 && n <= 20);
      c = (n <= 4) ? 0 : (n <= 12) ? 1 : (n <= 20) ? 2 : (n <= 22) ? 3 : 0;
      tbl[k] = '{(k < 22), 1'b0, 1'b0, pack(r, n <= 22, 1'b0, 1'b0, n == 21, c)};
    end

    do_reset();
    for (int k = 0; k < 23; k++) begin
      tick(tbl[k].cr, tbl[k].an, tbl[k].di, "timeout");
      check($sformatf("timeout c%0d", k + 1), dut_vec(), tbl[k].exp);
    end

    // Answer during burst 2.
    for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 1'b0, "answer");
    tick(1'b1, 1'b1, 1'b0, "answer");
    check("answer c11", dut_vec(), pack(0, 1, 1, 0, 0, 1));
    for (int k = 0; k < 25; k++) tick(1'b1, 1'b0, 1'b0, "answer hold");
    check("answer hold no missed", dut_vec(), pack(0, 1, 0, 0, 0, 1));
    tick(1'b0, 1'b0, 1'b0, "answer drop");
    check("answer drop idle", dut_vec(), 8'h00);

    // Dismiss during silence; later answers are ignored in HOLD.
    for (int k = 0; k < 6; k++) tick(1'b1, 1'b0, 1'b0, "dismiss");
    tick(1'b1, 1'b0, 1'b1, "dismiss");
    check("dismiss c7", dut_vec(), pack(0, 1, 0, 1, 0, 1));
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 1'b0, "dismiss hold");
      check("dismiss hold answer ignored", dut_vec(), pack(0, 1, 0, 0, 0, 1));
    end
    tick(1'b0, 1'b0, 1'b0, "dismiss drop");

    // Answer/dismiss in idle are ignored.
    tick(1'b0, 1'b1, 1'b0, "idle");
    tick(1'b0, 1'b0, 1'b1, "idle");
    check("idle ignores user", dut_vec(), 8'h00);

    // Hang-up beats answer in the same cycle.
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, "hangup");
    tick(1'b0, 1'b1, 1'b0, "hangup");
    check("hangup c4", dut_vec(), 8'h00);

    // Answer on the last cycle of the final burst.
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0, 1'b0, "boundary");
    tick(1'b1, 1'b1, 1'b0, "boundary");
    check("boundary c21", dut_vec(), pack(0, 1, 1, 0, 0, 2));
    tick(1'b1, 1'b0, 1'b0, "boundary");
    check("boundary c22", dut_vec(), pack(0, 1, 0, 0, 0, 2));
    tick(1'b0, 1'b0, 1'b0, "boundary drop");

    // Asynchronous reset mid-burst.
    tick(1'b1, 1'b0, 1'b0, "async");
    tick(1'b1, 1'b0, 1'b0, "async");
    check("async pre", dut_vec(), pack(1, 1, 0, 0, 0, 0));
    #2 reset_n = 1'b0;
    #1 check("async drop before edge", dut_vec(), 8'h00);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, 1'b0, "async restart");
      if (k == 0) check("async restart c1", dut_vec(), pack(1, 1, 0, 0, 0, 0));
      if (k == 4) check("async restart c5", dut_vec(), pack(0, 1, 0, 0, 0, 1));
    end

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      logic c;
      logic a;
      logic d;
      if (m_mode == 0) c = ($urandom % 4) == 0;
      else c = ($urandom % 50) != 0;
      a = ($urandom % 25) == 0;
      d = ($urandom % 25) == 0;
      tick(c, a, d, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
